// File: rtl/soc_epoch_driver_pkg.sv
// rtl/soc_epoch_driver_pkg.sv - shared types for the SoC-side epoch driver
package soc_epoch_driver_pkg;

    typedef logic [15:0] AdcData_t;
    typedef logic [2:0]  SleepStage_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EPOCH,
        ST_LOAD,
        ST_STREAM,
        ST_WAIT_INF,
        ST_DONE
    } EpochDrvState_t;

endpackage

// File: rtl/soc_epoch_driver_sync_fifo.sv
// rtl/soc_epoch_driver_sync_fifo.sv - type-parameterised synchronous FIFO with flush
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    input  logic flush,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int AW = $clog2(DEPTH);

    T           mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot this cycle, so a push at full is still accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/soc_epoch_driver.sv
// rtl/soc_epoch_driver.sv - buffers ADC samples and sequences one epoch to the accelerator
module soc_epoch_driver
    import soc_epoch_driver_pkg::*;
#(
    parameter int NUM_SAMPLES    = 3000,
    parameter int SAMPLE_GAP     = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        epoch_tick,
    input  logic        adc_valid,
    input  AdcData_t    adc_data,
    input  logic        inference_complete,
    input  SleepStage_t inferred_sleep_stage,
    output logic        new_sleep_epoch,
    output logic        start_eeg_load,
    output logic        new_eeg_data,
    output AdcData_t    eeg,
    output logic        stage_valid,
    output SleepStage_t stage,
    output logic        busy,
    output logic        err_overrun,
    output logic        err_timeout,
    output logic        err_epoch_missed,
    output logic        err_protocol
);
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(SAMPLE_GAP + 1);
    localparam logic [CW-1:0] NUM_C    = CW'(NUM_SAMPLES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(SAMPLE_GAP - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    // Each entry remembers its sample index so dropped slots can be replayed as zeros in order.
    typedef struct packed {
        logic [CW-1:0] idx;
        AdcData_t      data;
    } entry_t;

    EpochDrvState_t state_q, state_d;
    logic [CW-1:0]  push_cnt_q, push_cnt_d, pop_cnt_q, pop_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]  timeout_cnt_q, timeout_cnt_d;
    logic           new_sleep_epoch_q, new_sleep_epoch_d, start_eeg_load_q, start_eeg_load_d;
    logic           new_eeg_data_q, new_eeg_data_d, stage_valid_q, stage_valid_d;
    AdcData_t       eeg_q, eeg_d;
    SleepStage_t    stage_q, stage_d;
    logic           err_overrun_q, err_overrun_d, err_timeout_q, err_timeout_d;
    logic           err_epoch_missed_q, err_epoch_missed_d, err_protocol_q, err_protocol_d;

    logic   fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    entry_t fifo_in, fifo_head;
    logic   sample_in, strobe_go, head_match;

    sync_fifo #(.T(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign sample_in  = (state_q inside {ST_EPOCH, ST_LOAD, ST_STREAM}) && adc_valid && (push_cnt_q < NUM_C);
    assign fifo_in    = '{idx: push_cnt_q, data: adc_data};
    assign head_match = !fifo_empty && (fifo_head.idx == pop_cnt_q);
    // An empty FIFO with pop behind push means the next slot was a dropped sample.
    assign strobe_go  = (state_q == ST_STREAM) && (gap_cnt_q == '0) && (pop_cnt_q < NUM_C)
                        && (!fifo_empty || (pop_cnt_q < push_cnt_q));
    assign fifo_pop   = strobe_go && head_match;
    assign fifo_push  = sample_in;

    always_comb begin
        state_d            = state_q;
        push_cnt_d         = push_cnt_q;
        pop_cnt_d          = pop_cnt_q;
        gap_cnt_d          = gap_cnt_q;
        timeout_cnt_d      = timeout_cnt_q;
        new_sleep_epoch_d  = 1'b0;
        start_eeg_load_d   = 1'b0;
        new_eeg_data_d     = 1'b0;
        stage_valid_d      = 1'b0;
        eeg_d              = eeg_q;
        stage_d            = stage_q;
        err_overrun_d      = err_overrun_q;
        err_timeout_d      = err_timeout_q;
        err_epoch_missed_d = err_epoch_missed_q || (epoch_tick && state_q != ST_IDLE);
        err_protocol_d     = err_protocol_q || (inference_complete && state_q != ST_WAIT_INF);
        fifo_flush         = 1'b0;

        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GW'(1);

        if (sample_in) begin
            push_cnt_d = push_cnt_q + CW'(1);
            if (fifo_full && !fifo_pop) err_overrun_d = 1'b1;
        end

        if (strobe_go) begin
            new_eeg_data_d = 1'b1;
            eeg_d          = head_match ? fifo_head.data : '0;
            gap_cnt_d      = GAP_LOAD;
            pop_cnt_d      = pop_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: if (epoch_tick) begin
                fifo_flush        = 1'b1;
                push_cnt_d        = '0;
                pop_cnt_d         = '0;
                new_sleep_epoch_d = 1'b1;
                state_d           = ST_EPOCH;
            end
            ST_EPOCH: begin
                start_eeg_load_d = 1'b1;
                state_d          = ST_LOAD;
            end
            ST_LOAD:   state_d = ST_STREAM;
            ST_STREAM: if (pop_cnt_d == NUM_C) begin
                timeout_cnt_d = '0;
                state_d       = ST_WAIT_INF;
            end
            ST_WAIT_INF: begin
                if (inference_complete) begin
                    stage_d       = inferred_sleep_stage;
                    stage_valid_d = 1'b1;
                    state_d       = ST_DONE;
                end else if (timeout_cnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + TW'(1);
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            push_cnt_q         <= '0;
            pop_cnt_q          <= '0;
            gap_cnt_q          <= '0;
            timeout_cnt_q      <= '0;
            new_sleep_epoch_q  <= 1'b0;
            start_eeg_load_q   <= 1'b0;
            new_eeg_data_q     <= 1'b0;
            stage_valid_q      <= 1'b0;
            eeg_q              <= '0;
            stage_q            <= '0;
            err_overrun_q      <= 1'b0;
            err_timeout_q      <= 1'b0;
            err_epoch_missed_q <= 1'b0;
            err_protocol_q     <= 1'b0;
        end else begin
            state_q            <= state_d;
            push_cnt_q         <= push_cnt_d;
            pop_cnt_q          <= pop_cnt_d;
            gap_cnt_q          <= gap_cnt_d;
            timeout_cnt_q      <= timeout_cnt_d;
            new_sleep_epoch_q  <= new_sleep_epoch_d;
            start_eeg_load_q   <= start_eeg_load_d;
            new_eeg_data_q     <= new_eeg_data_d;
            stage_valid_q      <= stage_valid_d;
            eeg_q              <= eeg_d;
            stage_q            <= stage_d;
            err_overrun_q      <= err_overrun_d;
            err_timeout_q      <= err_timeout_d;
            err_epoch_missed_q <= err_epoch_missed_d;
            err_protocol_q     <= err_protocol_d;
        end
    end

    assign new_sleep_epoch  = new_sleep_epoch_q;
    assign start_eeg_load   = start_eeg_load_q;
    assign new_eeg_data     = new_eeg_data_q;
    assign eeg              = eeg_q;
    assign stage_valid      = stage_valid_q;
    assign stage            = stage_q;
    assign busy             = (state_q != ST_IDLE);
    assign err_overrun      = err_overrun_q;
    assign err_timeout      = err_timeout_q;
    assign err_epoch_missed = err_epoch_missed_q;
    assign err_protocol     = err_protocol_q;

endmodule

// File: tb/tb_soc_epoch_driver.sv
// tb/tb_soc_epoch_driver.sv - randomized self-checking bench for soc_epoch_driver
module tb_soc_epoch_driver;
    import soc_epoch_driver_pkg::*;

    logic        clk, rst_n, epoch_tick, adc_valid, ic;
    AdcData_t    adc_data;
    SleepStage_t iss;

    logic        nse [3], sel_o [3], ned [3], sv [3], busy_o [3];
    logic        eo [3], et [3], em [3], ep [3];
    AdcData_t    eeg_o [3];
    SleepStage_t stg [3];

    // Instance 0: nominal (gap 2, depth 4); 1: gap 8; 2: depth 2.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        soc_epoch_driver #(
            .NUM_SAMPLES(4), .SAMPLE_GAP(g == 1 ? 8 : 2),
            .FIFO_DEPTH(g == 2 ? 2 : 4), .TIMEOUT_CYCLES(50)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .epoch_tick(epoch_tick),
            .adc_valid(adc_valid), .adc_data(adc_data),
            .inference_complete(ic), .inferred_sleep_stage(iss),
            .new_sleep_epoch(nse[g]), .start_eeg_load(sel_o[g]),
            .new_eeg_data(ned[g]), .eeg(eeg_o[g]),
            .stage_valid(sv[g]), .stage(stg[g]), .busy(busy_o[g]),
            .err_overrun(eo[g]), .err_timeout(et[g]),
            .err_epoch_missed(em[g]), .err_protocol(ep[g])
        );
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sel = 0;

    logic [15:0] sq [$];
    int          st [$];
    logic [2:0]  svq [$];
    int          svt [$];
    int          nset [$];
    int          slt [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ned[sel])   begin sq.push_back(eeg_o[sel]); st.push_back(cyc); end
        if (sv[sel])    begin svq.push_back(stg[sel]); svt.push_back(cyc); end
        if (nse[sel])   nset.push_back(cyc);
        if (sel_o[sel]) slt.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        sq.delete(); st.delete(); svq.delete(); svt.delete(); nset.delete(); slt.delete();
    endtask

    task automatic do_reset(input int s);
        sel = s; rst_n = 1'b0; epoch_tick = 1'b0; adc_valid = 1'b0; ic = 1'b0;
        step(2);
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic tick();
        epoch_tick = 1'b1; step(1); epoch_tick = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input int space, output int pc);
        adc_valid = 1'b1; adc_data = d; pc = cyc + 1;
        step(1);
        adc_valid = 1'b0;
        if (space > 1) step(space - 1);
    endtask

    task automatic infer(input logic [2:0] s, output int icc);
        ic = 1'b1; iss = s; icc = cyc;
        step(1);
        ic = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input string nm);
        int k = 0;
        while (st.size() < n && k < 300) begin step(1); k++; end
        checks++;
        if (st.size() < n) begin
            failures++; $display("FAIL %s_strobe_wait got=%0d want=%0d", nm, st.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; epoch_tick = 1'b1; adc_valid = 1'b1; adc_data = 16'hBEEF; ic = 1'b1; iss = 3'd7;
        step(2);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({nse[g], sel_o[g], ned[g], eeg_o[g], sv[g], stg[g], busy_o[g], eo[g], et[g], em[g], ep[g]} !== '0) begin
                failures++; $display("FAIL reset_outputs inst=%0d got busy=%b eeg=%h errs=%b%b%b%b want all zero",
                                     g, busy_o[g], eeg_o[g], eo[g], et[g], em[g], ep[g]);
            end
        end
        rst_n = 1'b1; epoch_tick = 1'b0; adc_valid = 1'b0; ic = 1'b0;
        step(2);
        checks++;
        if (busy_o[0] !== 1'b0) begin failures++; $display("FAIL reset_idle got busy=%b want 0", busy_o[0]); end
    endtask

    task automatic test_nominal();
        int pc, icc;
        logic [15:0] exp_d;
        do_reset(0);
        tick();
        for (int i = 0; i < 4; i++) send(16'h0011 + 16'(i), 1, pc);
        wait_strobes(4, "nominal");
        step(10);
        infer(3'd3, icc);
        step(3);
        checks++;
        if (nset.size() != 1 || slt.size() != 1 || slt[0] != nset[0] + 1) begin
            failures++; $display("FAIL nominal_handshake got nse=%0d sel=%0d want load one cycle after epoch", nset.size(), slt.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 16'h0011 + 16'(i);
            checks++;
            if (sq.size() <= i || sq[i] !== exp_d) begin
                failures++; $display("FAIL nominal_eeg[%0d] got=%h want=%h", i, (sq.size() > i) ? sq[i] : 16'hxxxx, exp_d);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (st.size() > i && st[i] - st[i-1] < 2) begin
                failures++; $display("FAIL nominal_gap[%0d] got=%0d want>=2", i, st[i] - st[i-1]);
            end
        end
        checks++;
        if (svq.size() != 1 || svq[0] !== 3'd3 || svt[0] != icc + 1) begin
            failures++; $display("FAIL nominal_stage got count=%0d stage=%0d want 1 strobe stage=3 at +1", svq.size(), stg[0]);
        end
        checks++;
        if ({eo[0], et[0], em[0], ep[0], busy_o[0]} !== 5'b0) begin
            failures++; $display("FAIL nominal_flags got=%b%b%b%b busy=%b want 0", eo[0], et[0], em[0], ep[0], busy_o[0]);
        end
    endtask

    task automatic test_random();
        int pc, icc, sp;
        logic [15:0] exp_q [$];
        logic [2:0]  s;
        do_reset(0);
        for (int e = 0; e < 3; e++) begin
            clear_q();
            exp_q.delete();
            tick();
            // Arrivals no faster than the strobe spacing never overrun, so the stream is the input in order.
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(16'($urandom));
                sp = $urandom_range(2, 5);
                send(exp_q[i], sp, pc);
            end
            wait_strobes(4, "random");
            step($urandom_range(1, 8));
            s = 3'($urandom_range(0, 7));
            infer(s, icc);
            step(3);
            checks++;
            if (sq != exp_q) begin
                failures++; $display("FAIL random_stream epoch=%0d got=%p want=%p", e, sq, exp_q);
            end
            checks++;
            if (svq.size() != 1 || svq[0] !== s || svt[0] != icc + 1) begin
                failures++; $display("FAIL random_stage epoch=%0d got=%0d want=%0d", e, stg[0], s);
            end
        end
        checks++;
        if ({eo[0], et[0], em[0], ep[0]} !== 4'b0) begin
            failures++; $display("FAIL random_flags got=%b%b%b%b want 0000", eo[0], et[0], em[0], ep[0]);
        end
    endtask

    task automatic test_overrun();
        int pc, icc;
        logic [15:0] exp_q [$];
        do_reset(1);
        tick();
        for (int i = 0; i < 6; i++) send(16'h00A0 + 16'(i), 1, pc);
        exp_q = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        wait_strobes(4, "excess");
        step(12);
        infer(3'd2, icc);
        step(3);
        checks++;
        if (sq != exp_q) begin failures++; $display("FAIL excess_stream got=%p want=%p", sq, exp_q); end
        checks++;
        if (eo[1] !== 1'b0 || svq.size() != 1 || stg[1] !== 3'd2) begin
            failures++; $display("FAIL excess_flags got ovr=%b stage=%0d want ovr=0 stage=2", eo[1], stg[1]);
        end

        do_reset(2);
        tick();
        for (int i = 0; i < 4; i++) send(16'h00B0 + 16'(i), 1, pc);
        // Depth 2: the fourth sample arrives while the FIFO is full between strobes.
        exp_q = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h0000};
        wait_strobes(4, "overrun");
        step(2);
        infer(3'd1, icc);
        step(3);
        checks++;
        if (sq != exp_q) begin failures++; $display("FAIL overrun_stream got=%p want=%p", sq, exp_q); end
        checks++;
        if (eo[2] !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b want=1", eo[2]); end
    endtask

    task automatic test_timeout();
        int pc, c4, k;
        do_reset(0);
        tick();
        for (int i = 0; i < 4; i++) send(16'h00C0 + 16'(i), 1, pc);
        wait_strobes(4, "timeout");
        c4 = (st.size() == 4) ? st[3] : cyc;
        k = 0;
        while (et[0] !== 1'b1 && k < 200) begin step(1); k++; end
        checks++;
        if (et[0] !== 1'b1 || cyc != c4 + 50) begin
            failures++; $display("FAIL timeout_cycle got=%0d want=%0d", cyc - c4, 50);
        end
        checks++;
        if (busy_o[0] !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b want=0", busy_o[0]); end
        step(3);
        checks++;
        if (svq.size() != 0 || stg[0] !== 3'd0) begin
            failures++; $display("FAIL timeout_no_stage got count=%0d stage=%0d want 0", svq.size(), stg[0]);
        end
    endtask

    task automatic test_protocol();
        int pc, icc, junk;
        logic [15:0] exp_q [$];
        do_reset(0);
        tick();
        for (int i = 0; i < 4; i++) send(16'h00D0 + 16'(i), 1, pc);
        exp_q = '{16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3};
        infer(3'd6, junk);
        wait_strobes(4, "protocol");
        tick();
        step(1);
        infer(3'd5, icc);
        step(3);
        checks++;
        if (ep[0] !== 1'b1 || em[0] !== 1'b1) begin
            failures++; $display("FAIL protocol_flags got prot=%b missed=%b want 1 1", ep[0], em[0]);
        end
        checks++;
        if (svq.size() != 1 || svq[0] !== 3'd5 || svt[0] != icc + 1 || nset.size() != 1) begin
            failures++; $display("FAIL protocol_stage got count=%0d stage=%0d epochs=%0d want 1 5 1", svq.size(), stg[0], nset.size());
        end
        checks++;
        if (sq != exp_q) begin failures++; $display("FAIL protocol_stream got=%p want=%p", sq, exp_q); end
    endtask

    task automatic test_reset_mid();
        int pc, icc;
        logic [15:0] exp_q [$];
        do_reset(0);
        tick();
        for (int i = 0; i < 4; i++) send(16'h00E0 + 16'(i), 1, pc);
        wait_strobes(2, "midreset");
        rst_n = 1'b0;
        step(1);
        checks++;
        if ({nse[0], sel_o[0], ned[0], eeg_o[0], sv[0], stg[0], busy_o[0], eo[0], et[0], em[0], ep[0]} !== '0) begin
            failures++; $display("FAIL midreset_outputs got busy=%b ned=%b eeg=%h want all zero", busy_o[0], ned[0], eeg_o[0]);
        end
        rst_n = 1'b1;
        clear_q();
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(16'h0F00 + 16'(i));
            send(exp_q[i], 2, pc);
        end
        wait_strobes(4, "fresh");
        infer(3'd4, icc);
        step(3);
        checks++;
        if (sq != exp_q) begin failures++; $display("FAIL fresh_stream got=%p want=%p", sq, exp_q); end
        checks++;
        if (svq.size() != 1 || svq[0] !== 3'd4 || {eo[0], et[0], em[0], ep[0]} !== 4'b0) begin
            failures++; $display("FAIL fresh_result got stage=%0d errs=%b%b%b%b want 4 0000", stg[0], eo[0], et[0], em[0], ep[0]);
        end
    endtask

    task automatic test_underrun();
        int pc [4];
        int icc;
        do_reset(0);
        tick();
        step(3);
        for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i), 10, pc[i]);
        wait_strobes(4, "underrun");
        infer(3'd7, icc);
        step(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st.size() <= i || st[i] != pc[i] + 1 || sq[i] !== 16'h0100 + 16'(i)) begin
                failures++; $display("FAIL underrun_strobe[%0d] got cyc=%0d want=%0d", i, (st.size() > i) ? st[i] : -1, pc[i] + 1);
            end
        end
        checks++;
        if (st.size() != 4 || {eo[0], et[0], em[0], ep[0]} !== 4'b0) begin
            failures++; $display("FAIL underrun_flags got strobes=%0d errs=%b%b%b%b want 4 0000", st.size(), eo[0], et[0], em[0], ep[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; epoch_tick = 1'b0; adc_valid = 1'b0; adc_data = '0; ic = 1'b0; iss = '0;
        step(1);
        test_reset();
        test_nominal();
        test_random();
        test_overrun();
        test_timeout();
        test_protocol();
        test_reset_mid();
        test_underrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/soc_epoch_driver.md
Name: soc_epoch_driver

Overview:
- SoC-side master of the accelerator's SoC data interface.
- Drives the signals the accelerator receives: new_sleep_epoch, start_eeg_load, new_eeg_data and eeg.
- Consumes the signals the accelerator returns: inference_complete and inferred_sleep_stage.
- Per epoch: buffers ADC samples in a small FIFO, sequences the epoch/load handshake, streams exactly one epoch of samples, waits for the inference result and reports it upstream with error flags.

Parameters:
- NUM_SAMPLES, 3000: EEG samples per sleep epoch.
- SAMPLE_GAP, 2: minimum clk cycles between consecutive new_eeg_data pulses (≥1).
- FIFO_DEPTH, 8: ADC sample buffer depth (power of 2, ≥2).
- TIMEOUT_CYCLES, 1000000: maximum wait for inference_complete after the last sample.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- epoch_tick  in  1  1-cycle request to start a new epoch
- adc_valid  in  1  ADC sample strobe
- adc_data  in  AdcData_t  ADC sample
- inference_complete  in  1  accelerator result strobe
- inferred_sleep_stage  in  SleepStage_t  accelerator result
- new_sleep_epoch  out  1  pulse to accelerator
- start_eeg_load  out  1  pulse to accelerator
- new_eeg_data  out  1  sample strobe to accelerator
- eeg  out  AdcData_t  sample to accelerator
- stage_valid  out  1  1-cycle result strobe upstream
- stage  out  SleepStage_t  latched result
- busy  out  1  high in any state except IDLE
- err_overrun  out  1  sticky: ADC sample dropped
- err_timeout  out  1  sticky: no result within TIMEOUT_CYCLES
- err_epoch_missed  out  1  sticky: epoch_tick while busy
- err_protocol  out  1  sticky: inference_complete outside WAIT_INF

Behaviour:
- Reset: all outputs 0; FSM to IDLE; FIFO empty; all counters 0. The same applies to reset asserted mid-operation. Sticky flags clear only on reset.
- FSM states: IDLE, EPOCH, LOAD, STREAM, WAIT_INF, DONE.
- IDLE: on epoch_tick, flush FIFO, clear push_cnt/pop_cnt, go to EPOCH. ADC samples arriving in IDLE are discarded and no error is set.
- EPOCH: new_sleep_epoch=1 for exactly this cycle, then go to LOAD.
- LOAD: start_eeg_load=1 for exactly this cycle, then go to STREAM.
- FIFO push (states EPOCH, LOAD, STREAM):
  - Condition: adc_valid && push_cnt<NUM_SAMPLES.
  - Push accepted if FIFO is not full, or if a pop occurs in the same cycle. Otherwise the sample is dropped, err_overrun=1, and push_cnt still increments, so the epoch stays aligned.
  - Samples beyond NUM_SAMPLES are ignored without error.
- STREAM pop:
  - Condition: FIFO non-empty && gap_cnt==0 && pop_cnt<NUM_SAMPLES.
  - Registered outputs: eeg=head and new_eeg_data=1 for one cycle; gap_cnt loads SAMPLE_GAP-1.
  - eeg holds its value between strobes.
- Underrun is not an error; the next strobe waits until data arrives.
- Dropped samples are still counted for streaming: for each dropped sample, one strobe with eeg=0 is emitted at its turn. The accelerator always receives exactly NUM_SAMPLES strobes per epoch.
- Exit STREAM: when pop_cnt reaches NUM_SAMPLES, go to WAIT_INF and clear timeout_cnt.
- WAIT_INF:
  - On inference_complete: latch stage=inferred_sleep_stage, go to DONE.
  - If timeout_cnt==TIMEOUT_CYCLES-1: err_timeout=1, stage unchanged, go to IDLE with no stage_valid.
- DONE: stage_valid=1 for one cycle, then go to IDLE. Latency from inference_complete to stage_valid is 1 cycle.
- epoch_tick in any state except IDLE is ignored and sets err_epoch_missed. epoch_tick in the DONE cycle also counts as missed.
- inference_complete outside WAIT_INF sets err_protocol and is otherwise ignored.
- Counters are sized $clog2(NUM_SAMPLES+1) and saturate logically via their state guards; no wrap occurs within an epoch. FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.

Decomposition:
- Defines package: AdcData_t (16-bit), SleepStage_t (3-bit), and the new EpochDrvState_t enum.
- Sub-module sync_fifo:
  - Parameterised by type and depth.
  - Ports: push, pop, flush, full, empty, head.
  - Same-cycle push+pop is legal at full and at empty. At empty, the pop is ignored.

Test Plan (NUM_SAMPLES=4, SAMPLE_GAP=2, FIFO_DEPTH=4, TIMEOUT_CYCLES=50):
- Nominal: epoch_tick; adc samples 0x0011..0x0014 back-to-back; inference_complete with stage=3 after 10 cycles.
  - new_sleep_epoch, then start_eeg_load on the next cycle.
  - 4 new_eeg_data strobes ≥2 cycles apart carrying 0x0011..0x0014 in order.
  - stage_valid with stage=3 exactly 1 cycle after inference_complete; no error flags.
- Overrun: SAMPLE_GAP=8, 6 samples pushed back-to-back.
  - Samples 5 and 6 beyond NUM_SAMPLES are ignored, err_overrun stays 0.
  - Separately, FIFO_DEPTH=2 with 4 back-to-back samples: err_overrun=1, and still exactly 4 strobes with zeros in the dropped slots.
- Timeout: stream 4 samples, never assert inference_complete.
  - err_timeout=1 50 cycles after entering WAIT_INF; no stage_valid; busy=0 the cycle after.
- Protocol/missed: inference_complete during STREAM and epoch_tick during WAIT_INF.
  - err_protocol=1, err_epoch_missed=1.
  - The current epoch completes normally with the correct stage.
- Reset mid-STREAM after 2 strobes.
  - All outputs 0 the next cycle.
  - A fresh epoch_tick produces a clean 4-sample epoch with no stale FIFO data.
- Underrun: samples arrive 10 cycles apart.
  - Each strobe follows its push by 1 cycle.
  - Exactly 4 strobes; no error flags.
